// File: rtl/uart_txq.sv
// Queued UART transmitter: a TX FIFO feeding a tick-paced frame FSM with
// per-frame latched format, parity, break and flush handling.
module uart_txq #(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             sys_clk,
  input  logic             rst_b,
  input  logic             baud_tick,
  input  logic             wr_vld,
  input  logic [7:0]       wr_data,
  output logic             wr_rdy,
  input  logic [1:0]       cfg_data_len,
  input  logic             cfg_par_en,
  input  logic [1:0]       cfg_par_mode,
  input  logic             cfg_stop2,
  input  logic             brk,
  input  logic             flush,
  output logic             s_out,
  output logic [LVL_W-1:0] fifo_level,
  output logic             tx_busy,
  output logic             tx_empty,
  output logic             tx_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity over the 5+len transmitted bits only; bits above the frame width are masked off.
  function automatic logic par_calc(input logic [7:0] d, input logic [1:0] len, input logic [1:0] mode);
    logic [7:0] m;
    m = 8'hFF >> (2'd3 - len);
    case (mode)
      2'b00:   par_calc = ~(^(d & m));
      2'b01:   par_calc = ^(d & m);
      2'b10:   par_calc = 1'b1;
      2'b11:   par_calc = 1'b0;
      default: par_calc = 1'b0;
    endcase
  endfunction

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r, level_s;
  state_t           state_r, state_s;
  logic [7:0]       shreg_r;
  logic [2:0]       bit_cnt_r;
  logic             stop_cnt_r;
  logic [1:0]       len_r, mode_r;
  logic             par_en_r, stop2_r, par_bit_r;
  logic             s_out_r, done_r, busy_r, empty_r;
  logic             full_s, push_s, avail_s, pop_s, sout_s, done_s, shift_s;

  assign full_s  = (level_r == LVL_W'(FIFO_DEPTH));
  assign push_s  = wr_vld && !full_s && !flush;
  // A flushing cycle must not start a frame from data that is being discarded.
  assign avail_s = (level_r != {LVL_W{1'b0}}) && !flush && !brk;

  assign wr_rdy     = !full_s;
  assign fifo_level = level_r;
  assign s_out      = s_out_r;
  assign tx_done    = done_r;
  assign tx_busy    = busy_r;
  assign tx_empty   = empty_r;

  // Frame FSM next state, pop request and next serial-line value.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    sout_s  = s_out_r;
    done_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (baud_tick && avail_s) begin
          pop_s   = 1'b1;
          state_s = START;
          sout_s  = 1'b0;
        end else begin
          sout_s = !brk;
        end
      end
      START: begin
        if (baud_tick) begin
          state_s = DATA;
          sout_s  = shreg_r[0];
          shift_s = 1'b1;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_r == ({1'b0, len_r} + 3'd4)) begin
            if (par_en_r) begin
              state_s = PARITY;
              sout_s  = par_bit_r;
            end else begin
              state_s = STOP;
              sout_s  = 1'b1;
            end
          end else begin
            sout_s  = shreg_r[0];
            shift_s = 1'b1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_s = STOP;
          sout_s  = 1'b1;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (baud_tick && (stop_cnt_r == stop2_r)) begin
          done_s = 1'b1;
          if (avail_s) begin
            pop_s   = 1'b1;
            state_s = START;
            sout_s  = 1'b0;
          end else begin
            state_s = IDLE;
            sout_s  = !brk;
          end
        end else begin
          sout_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        sout_s  = 1'b1;
      end
    endcase
  end

  // Next FIFO occupancy; flush wins over any push.
  always_comb begin
    level_s = level_r;
    if (flush) begin
      level_s = {LVL_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_s = level_r + LVL_W'(1);
        2'b01:   level_s = level_r - LVL_W'(1);
        default: level_s = level_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r <= level_s;
    end
  end

  // FSM state, shift register, per-frame format registers and status outputs.
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r    <= IDLE;
      shreg_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      len_r      <= 2'd0;
      mode_r     <= 2'd0;
      par_en_r   <= 1'b0;
      stop2_r    <= 1'b0;
      par_bit_r  <= 1'b0;
      s_out_r    <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      empty_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      s_out_r <= sout_s;
      done_r  <= done_s;
      busy_r  <= (state_s != IDLE);
      empty_r <= (state_s == IDLE) && (level_s == {LVL_W{1'b0}});
      if (pop_s) begin
        shreg_r   <= mem_r[rd_ptr_r];
        len_r     <= cfg_data_len;
        mode_r    <= cfg_par_mode;
        par_en_r  <= cfg_par_en;
        stop2_r   <= cfg_stop2;
        par_bit_r <= par_calc(mem_r[rd_ptr_r], cfg_data_len, cfg_par_mode);
        bit_cnt_r <= 3'd0;
      end else if (shift_s) begin
        shreg_r <= {1'b0, shreg_r[7:1]};
        if (state_r == DATA) bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (state_r != STOP) begin
        stop_cnt_r <= 1'b0;
      end else if (baud_tick) begin
        stop_cnt_r <= 1'b1;
      end
    end
  end

endmodule
